biquad_coeff_loader: RTL and testbench
======================================

// Module: biquad_coeff_loader
// PURPOSE
// Coefficient sequencer for one biquad8_incremental instance. Host writes coefficients into a
// local staging bank; on request, the block shifts them into the DSP B-register cascade
// (coeff_dat/coeff_wr) last-entry-first. It then issues a single coeff_update strobe, optionally
// aligned to a system sync, so every DSP pair switches coefficients on the same clock.
// PARAMETERS
// NCOEFF       2   staging entries = B-cascade depth per DSP pair (entry NCOEFF-1 shifted first)
// ADRW         1   host address width; NCOEFF <= 2**ADRW
// SYNC_UPDATE  1   1: coeff_update waits for sync_i; 0: update issued right after the shift
// PORTS
// clk             in   1    clock
// rst             in   1    synchronous reset, active high
// host_adr_i      in   ADRW staging entry address
// host_dat_i      in   18   staging entry data (signed coefficient)
// host_wr_i       in   1    write strobe, 1 cycle
// load_i          in   1    start full sequence: shift all entries, then update
// update_only_i   in   1    start update-only sequence (no shift)
// sync_i          in   1    frame sync, 1-cycle pulse; used when SYNC_UPDATE=1
// coeff_dat_o     out  18   to biquad coeff_dat_i
// coeff_wr_o      out  1    to biquad coeff_wr_i
// coeff_update_o  out  1    to biquad coeff_update_i
// busy_o          out  1    sequence in progress
// done_o          out  1    1-cycle pulse at end of sequence
// err_o           out  1    1-cycle pulse: host write rejected
// BEHAVIOUR
// - Reset: all outputs 0, FSM -> IDLE, staging bank cleared to 0. Reset mid-sequence aborts at
//   once; no further wr/update pulses; partially shifted cascade is left as is (not updated).
// - Staging: host_wr_i in IDLE with host_adr_i < NCOEFF writes entry, visible to the next load.
//   Write while busy_o=1 or host_adr_i >= NCOEFF: ignored, err_o pulses the next cycle.
// - FSM: IDLE, SHIFT_WR, SHIFT_HOLD, WAIT_SYNC, UPDATE, DONE.
// - IDLE: load_i -> SHIFT_WR with k=NCOEFF-1; else update_only_i -> WAIT_SYNC (or UPDATE if
//   SYNC_UPDATE=0). load_i and update_only_i together: load_i wins. Starts only from IDLE;
//   load_i/update_only_i while busy ignored (no error, no queueing).
// - SHIFT_WR: coeff_wr_o=1, coeff_dat_o=stage[k]. SHIFT_HOLD: coeff_wr_o=0, coeff_dat_o held
//   (biquad registers the CE one cycle, so data must stay stable 2 cycles per entry).
//   After HOLD: k>0 -> k-1, SHIFT_WR; k=0 -> WAIT_SYNC (SYNC_UPDATE=1) or UPDATE.
// - WAIT_SYNC: sync_i sampled high -> UPDATE next cycle. sync_i outside WAIT_SYNC is ignored
//   (not latched). No timeout.
// - UPDATE: coeff_update_o=1 exactly one cycle. DONE: done_o=1 one cycle, busy_o=0, -> IDLE.
// - busy_o=1 in every state except IDLE and DONE. coeff_dat_o holds last value in IDLE.
// - Timing (load_i high at edge 0, SYNC_UPDATE=0): wr high in cycles 1,3,..,2*NCOEFF-1;
//   coeff_update_o in cycle 2*NCOEFF+1; done_o in 2*NCOEFF+2. NCOEFF=2: wr@1,3 upd@5 done@6.
// - Exactly NCOEFF coeff_wr_o pulses and one coeff_update_o per full sequence; never both high.
// TESTING
// - Write stage[0]=0x01234, stage[1]=0x3FFFF, load_i, SYNC_UPDATE=0 -> wr@1 dat=0x3FFFF,
//   wr@3 dat=0x01234, dat stable 2 cycles each, update@5, done@6, busy 1..5.
// - SYNC_UPDATE=1: load_i; sync_i at cycle 2 (ignored) and cycle 9 -> update@10, done@11.
// - update_only_i, SYNC_UPDATE=0 -> no wr pulses, update@1, done@2.
// - Host write during busy and to adr>=NCOEFF -> err_o pulse, stage unchanged; next load
//   shifts old values.
// - rst at cycle 3 of a load -> all outputs 0 at cycle 4, no update/done, stage reads 0.
// - Full loop with biquad8_incremental: load known coeffs, impulse in -> output matches
//   reference model; coefficients switch on a single clock after coeff_update_o.

Source files
------------

// File: rtl/biquad_coeff_loader.sv
// ---------------------------------------------------------------------------
// biquad_coeff_loader
//
// Coefficient sequencer for one biquad8_incremental instance. The host fills
// a small staging bank; on load_i the bank is shifted into the DSP B-register
// cascade last-entry-first. Each entry is presented for two cycles: one with
// coeff_wr_o high and one hold cycle, because the biquad registers its
// clock enable. After the shift a single coeff_update_o strobe is issued. It
// can optionally wait for a frame sync so that every DSP pair switches on the
// same clock. update_only_i issues the strobe without shifting.
//
// Ports
//   clk             clock
//   rst             synchronous reset, active high
//   host_adr_i      staging entry address (ADRW bits)
//   host_dat_i      staging entry data, signed 18-bit coefficient
//   host_wr_i       host write strobe, 1 cycle
//   load_i          start shift-then-update sequence
//   update_only_i   start update-only sequence
//   sync_i          frame sync pulse, used when SYNC_UPDATE=1
//   coeff_dat_o     cascade data to biquad coeff_dat_i
//   coeff_wr_o      cascade shift enable to biquad coeff_wr_i
//   coeff_update_o  coefficient switch strobe to biquad coeff_update_i
//   busy_o          sequence in progress
//   done_o          1-cycle pulse at end of sequence
//   err_o           1-cycle pulse when a host write was rejected
// ---------------------------------------------------------------------------
module biquad_coeff_loader #(
    parameter int NCOEFF      = 2,
    parameter int ADRW        = 1,
    parameter int SYNC_UPDATE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ADRW-1:0] host_adr_i,
    input  logic [17:0]     host_dat_i,
    input  logic            host_wr_i,
    input  logic            load_i,
    input  logic            update_only_i,
    input  logic            sync_i,
    output logic [17:0]     coeff_dat_o,
    output logic            coeff_wr_o,
    output logic            coeff_update_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    localparam int KW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
    localparam logic [KW-1:0]   K_LAST   = KW'(NCOEFF - 1);
    localparam logic [ADRW:0]   NCOEFF_A = (ADRW + 1)'(NCOEFF);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_WR,
        SHIFT_HOLD,
        WAIT_SYNC,
        UPDATE,
        DONE
    } state_t;

    state_t       state;
    logic [KW-1:0] k;
    logic [17:0]  stage [NCOEFF];
    logic         adr_ok;
    logic         wr_accept;

    // Address is checked one bit wider so NCOEFF == 2**ADRW compares cleanly.
    assign adr_ok    = ({1'b0, host_adr_i} < NCOEFF_A);
    // busy_o is low in IDLE and DONE, so writes are taken in either state.
    assign wr_accept = host_wr_i && !busy_o && adr_ok;

    // Staging bank: host writes land here and are only read by the shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCOEFF; i++) begin
                stage[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCOEFF; i++) begin
                if (wr_accept && ({1'b0, host_adr_i} == (ADRW + 1)'(i))) begin
                    stage[i] <= host_dat_i;
                end
            end
        end
    end

    // Sequencer. All outputs are registered and set on the edge that enters
    // the state they belong to. Pulse outputs therefore default low here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            k              <= '0;
            coeff_dat_o    <= '0;
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= host_wr_i && (busy_o || !adr_ok);

            case (state)
                IDLE: begin
                    if (load_i) begin
                        state       <= SHIFT_WR;
                        k           <= K_LAST;
                        coeff_wr_o  <= 1'b1;
                        coeff_dat_o <= stage[NCOEFF-1];
                        busy_o      <= 1'b1;
                    end else if (update_only_i) begin
                        busy_o <= 1'b1;
                        if (SYNC_UPDATE != 0) begin
                            state <= WAIT_SYNC;
                        end else begin
                            state          <= UPDATE;
                            coeff_update_o <= 1'b1;
                        end
                    end
                end

                SHIFT_WR: begin
                    state <= SHIFT_HOLD;
                end

                SHIFT_HOLD: begin
                    if (k != '0) begin
                        k           <= k - KW'(1);
                        state       <= SHIFT_WR;
                        coeff_wr_o  <= 1'b1;
                        coeff_dat_o <= stage[k - KW'(1)];
                    end else if (SYNC_UPDATE != 0) begin
                        state <= WAIT_SYNC;
                    end else begin
                        state          <= UPDATE;
                        coeff_update_o <= 1'b1;
                    end
                end

                // sync_i is only looked at here; earlier pulses are not latched.
                WAIT_SYNC: begin
                    if (sync_i) begin
                        state          <= UPDATE;
                        coeff_update_o <= 1'b1;
                    end
                end

                UPDATE: begin
                    state  <= DONE;
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_biquad_coeff_loader
//
// Two loader instances: dut0 with SYNC_UPDATE=0 and dut1 with SYNC_UPDATE=1.
// Both use NCOEFF=2 and ADRW=2, so addresses 2 and 3 are out of range. They
// share reset and the host bus. load/update_only/sync are separate per
// instance. Each vector is driven just after a falling edge. Its expected
// outputs are queued and compared at the next falling edge, after the DUT
// has taken the rising edge in between.
// ---------------------------------------------------------------------------
module tb_biquad_coeff_loader;

    logic        clk;
    logic        rst;
    logic [1:0]  host_adr;
    logic [17:0] host_dat;
    logic        host_wr;
    logic        load0, upd0;
    logic        load1, upd1, sync1;
    logic        sync0;

    logic [17:0] dat0, dat1;
    logic        wr0, wr1, cupd0, cupd1, busy0, busy1, done0, done1, err0, err1;

    typedef struct {
        int          idx;
        logic        sel;
        logic        rst;
        logic        wr;
        logic [1:0]  adr;
        logic [17:0] dat;
        logic        load;
        logic        upd;
        logic        sync;
        logic        e_wr;
        logic [17:0] e_dat;
        logic        e_upd;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    biquad_coeff_loader #(.NCOEFF(2), .ADRW(2), .SYNC_UPDATE(0)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .host_adr_i     (host_adr),
        .host_dat_i     (host_dat),
        .host_wr_i      (host_wr),
        .load_i         (load0),
        .update_only_i  (upd0),
        .sync_i         (sync0),
        .coeff_dat_o    (dat0),
        .coeff_wr_o     (wr0),
        .coeff_update_o (cupd0),
        .busy_o         (busy0),
        .done_o         (done0),
        .err_o          (err0)
    );

    biquad_coeff_loader #(.NCOEFF(2), .ADRW(2), .SYNC_UPDATE(1)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .host_adr_i     (host_adr),
        .host_dat_i     (host_dat),
        .host_wr_i      (host_wr),
        .load_i         (load1),
        .update_only_i  (upd1),
        .sync_i         (sync1),
        .coeff_dat_o    (dat1),
        .coeff_wr_o     (wr1),
        .coeff_update_o (cupd1),
        .busy_o         (busy1),
        .done_o         (done1),
        .err_o          (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic w, input logic [1:0] a,
                                input logic [17:0] d, input logic ld, input logic up,
                                input logic ewr, input logic [17:0] edat, input logic eupd,
                                input logic ebusy, input logic edone, input logic eerr);
        vec_t v;
        v.idx = 0;   v.sel = 1'b0; v.sync = 1'b0;
        v.rst = r;   v.wr = w;     v.adr = a;     v.dat = d;
        v.load = ld; v.upd = up;
        v.e_wr = ewr; v.e_dat = edat; v.e_upd = eupd;
        v.e_busy = ebusy; v.e_done = edone; v.e_err = eerr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        host_wr  = v.wr;
        host_adr = v.adr;
        host_dat = v.dat;
        load0    = v.sel ? 1'b0 : v.load;
        upd0     = v.sel ? 1'b0 : v.upd;
        load1    = v.sel ? v.load : 1'b0;
        upd1     = v.sel ? v.upd : 1'b0;
        sync1    = v.sync;
        exp_q.push_back(v);
    endtask

    task automatic cmp(input int idx, input string name, input logic [17:0] act,
                       input logic [17:0] want);
        total_cnt++;
        if (act === want) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL vec %0d %s: got 0x%0h expected 0x%0h", idx, name, act, want);
        end
    endtask

    task automatic checkOutput();
        vec_t        e;
        logic [17:0] a_dat;
        logic        a_wr, a_upd, a_busy, a_done, a_err;
        e = exp_q.pop_front();
        if (e.sel) begin
            a_dat = dat1; a_wr = wr1; a_upd = cupd1; a_busy = busy1; a_done = done1; a_err = err1;
        end else begin
            a_dat = dat0; a_wr = wr0; a_upd = cupd0; a_busy = busy0; a_done = done0; a_err = err0;
        end
        cmp(e.idx, "coeff_wr",     18'(a_wr),   18'(e.e_wr));
        cmp(e.idx, "coeff_dat",    a_dat,       e.e_dat);
        cmp(e.idx, "coeff_update", 18'(a_upd),  18'(e.e_upd));
        cmp(e.idx, "busy",         18'(a_busy), 18'(e.e_busy));
        cmp(e.idx, "done",         18'(a_done), 18'(e.e_done));
        cmp(e.idx, "err",          18'(a_err),  18'(e.e_err));
        cmp(e.idx, "wr_upd_exclusive", 18'(a_wr & a_upd), 18'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        rst = 1'b1; host_wr = 1'b0; host_adr = '0; host_dat = '0;
        load0 = 1'b0; upd0 = 1'b0; sync0 = 1'b0;
        load1 = 1'b0; upd1 = 1'b0; sync1 = 1'b0;

        // reset
        tbl.push_back(mk(1,0,0,18'h0,0,0,      0,18'h00000,0,0,0,0));
        tbl.push_back(mk(1,0,0,18'h0,0,0,      0,18'h00000,0,0,0,0));
        // staging writes, then full load
        tbl.push_back(mk(0,1,0,18'h01234,0,0,  0,18'h00000,0,0,0,0));
        tbl.push_back(mk(0,1,1,18'h3FFFF,0,0,  0,18'h00000,0,0,0,0));
        tbl.push_back(mk(0,0,0,18'h0,1,0,      1,18'h3FFFF,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h3FFFF,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      1,18'h01234,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,1,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,0,1,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,0,0,0));
        // update-only
        tbl.push_back(mk(0,0,0,18'h0,0,1,      0,18'h01234,1,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,0,1,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,0,0,0));
        // load and update_only together: load wins; write and load while busy
        tbl.push_back(mk(0,0,0,18'h0,1,1,      1,18'h3FFFF,0,1,0,0));
        tbl.push_back(mk(0,1,0,18'h00005,0,0,  0,18'h3FFFF,0,1,0,1));
        tbl.push_back(mk(0,0,0,18'h0,1,0,      1,18'h01234,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,1,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,0,1,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,0,0,0));
        // out-of-range addresses
        tbl.push_back(mk(0,1,2,18'h00777,0,0,  0,18'h01234,0,0,0,1));
        tbl.push_back(mk(0,1,3,18'h11111,0,0,  0,18'h01234,0,0,0,1));
        // reload: old values must come out
        tbl.push_back(mk(0,0,0,18'h0,1,0,      1,18'h3FFFF,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h3FFFF,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      1,18'h01234,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,1,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,0,1,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h01234,0,0,0,0));
        // new value, load, reset in cycle 3 of the load
        tbl.push_back(mk(0,1,1,18'h2AAAA,0,0,  0,18'h01234,0,0,0,0));
        tbl.push_back(mk(0,0,0,18'h0,1,0,      1,18'h2AAAA,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h2AAAA,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      1,18'h01234,0,1,0,0));
        tbl.push_back(mk(1,0,0,18'h0,0,0,      0,18'h00000,0,0,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h00000,0,0,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h00000,0,0,0,0));
        // after reset the bank reads back zero
        tbl.push_back(mk(0,0,0,18'h0,1,0,      1,18'h00000,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h00000,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      1,18'h00000,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h00000,0,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h00000,1,1,0,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h00000,0,0,1,0));
        tbl.push_back(mk(0,0,0,18'h0,0,0,      0,18'h00000,0,0,0,0));

        // SYNC_UPDATE=1 instance: stage writes, then load at c=0 with sync
        // pulses in cycle 2 (during the shift, ignored) and cycle 9.
        v = mk(0,1,0,18'h01234,0,0, 0,18'h00000,0,0,0,0); v.sel = 1'b1; tbl.push_back(v);
        v = mk(0,1,1,18'h3FFFF,0,0, 0,18'h00000,0,0,0,0); v.sel = 1'b1; tbl.push_back(v);
        for (int c = 0; c < 12; c++) begin
            int n;
            n = c + 1;
            v = mk(0, 0, 0, 18'h0, (c == 0), 0,
                   (n == 1 || n == 3), (n <= 2) ? 18'h3FFFF : 18'h01234,
                   (n == 10), (n >= 1 && n <= 10), (n == 11), 0);
            v.sel  = 1'b1;
            v.sync = (c == 2 || c == 9);
            tbl.push_back(v);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            tbl[i].idx = i;
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                checkOutput();
            end
            applyStimulus(tbl[i]);
        end
        @(negedge clk);
        checkOutput();

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
